maxpool_seq_ctrl: RTL and testbench

Sequencer that feeds the bit-serial 2:1 maxpool datapath (maxpool / maxpool_flex) from a parallel word stream.
- Accepts two full-width NO_CH-channel words, A then B, over a valid/ready handshake.
- Serialises them LSB-slice-first into one contiguous 2*CYC-cycle burst on the maxpool input.
- Captures the pooled result and presents it downstream on a buffered valid/ready output.
- Sits between the feature-map buffer and the maxpool instance. Includes abort, timeout error and a window counter.

---
 rtl/maxpool_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_maxpool_seq_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_seq_ctrl.sv
// maxpool_seq_ctrl: takes two parallel NO_CH-channel words (A, then B),
// plays them LSB slice first into the bit-serial maxpool as one gap-free
// burst of 2*CYC cycles, and holds the pooled result in a one-entry
// valid/ready output buffer. It also provides abort, a sticky timeout error
// and a wrapping count of delivered windows.
module maxpool_seq_ctrl #(
  parameter int NO_CH   = 10,
  parameter int BW_IN   = 4,
  parameter int SER_BW  = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      abort,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [NO_CH*BW_IN-1:0]    in_data,
  output logic                      mp_vld_in,
  output logic [NO_CH*SER_BW-1:0]   mp_data_in,
  input  logic                      mp_vld_out,
  input  logic [NO_CH*BW_IN-1:0]    mp_data_out,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [NO_CH*BW_IN-1:0]    out_data,
  output logic                      busy,
  output logic                      err,
  output logic [CNT_W-1:0]          win_cnt
);

  localparam int CYC = BW_IN / SER_BW;
  localparam int DW  = NO_CH * BW_IN;
  localparam int KW  = (2 * CYC > 1) ? $clog2(2 * CYC) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_B,
    ST_SHIFT,
    ST_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   a_q, b_q;
  logic [KW-1:0]   k_q;
  logic [TW-1:0]   timer_q;
  logic            obuf_free;
  logic            rdy_c;
  logic            cap_a, cap_b, load_res, set_err;
  logic [DW-1:0]   sel_w;
  int unsigned     si;

  assign obuf_free = !out_vld || out_rdy;
  assign busy      = (state_q != ST_IDLE);
  assign mp_vld_in = (state_q == ST_SHIFT);
  // in_rdy is held low while reset is asserted even though IDLE would raise it
  assign in_rdy    = rdy_c && rst;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic, handshake and capture strobes; abort overrides everything
  always_comb begin
    state_d  = state_q;
    rdy_c    = 1'b0;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    load_res = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy_c = 1'b1;
        if (in_vld) begin
          cap_a   = 1'b1;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        rdy_c = obuf_free;
        if (in_vld && obuf_free) begin
          cap_b   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (k_q == KW'(2 * CYC - 1)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mp_vld_out) begin
          load_res = 1'b1;
          state_d  = ST_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          set_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      rdy_c    = 1'b0;
      cap_a    = 1'b0;
      cap_b    = 1'b0;
      load_res = 1'b0;
      set_err  = 1'b0;
    end
  end

  // Operand registers, slice counter and wait timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      timer_q <= '0;
    end else begin
      if (cap_a) a_q <= in_data;
      if (cap_b) b_q <= in_data;
      if (cap_b)                        k_q <= '0;
      else if (state_q == ST_SHIFT)     k_q <= k_q + 1'b1;
      if (state_q == ST_SHIFT)          timer_q <= '0;
      else if (state_q == ST_WAIT)      timer_q <= timer_q + 1'b1;
    end
  end

  // Serial slice select: first CYC cycles come from A, the next CYC from B
  always_comb begin
    mp_data_in = '0;
    sel_w      = (k_q < KW'(CYC)) ? a_q : b_q;
    si         = int'(k_q);
    if (si >= CYC) si = si - CYC;
    if (state_q == ST_SHIFT) begin
      for (int unsigned c = 0; c < NO_CH; c++) begin
        mp_data_in[c*SER_BW +: SER_BW] = sel_w[c*BW_IN + si*SER_BW +: SER_BW];
      end
    end
  end

  // Output buffer, window counter and sticky error; a load beats a same-cycle drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      win_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      if (load_res) begin
        out_vld  <= 1'b1;
        out_data <= mp_data_out;
        win_cnt  <= win_cnt + 1'b1;
      end else if (out_rdy) begin
        out_vld  <= 1'b0;
      end
      if (set_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Testbench for maxpool_seq_ctrl: a behavioural signed 2:1 maxpool stub
// sits on the serial side; expected slices and results are queued when
// words are handed to the DUT and compared when the DUT emits them.
module tb_maxpool_seq_ctrl;

  localparam int NO_CH   = 10;
  localparam int BW_IN   = 4;
  localparam int SER_BW  = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 3;
  localparam int CYC     = BW_IN / SER_BW;
  localparam int DW      = NO_CH * BW_IN;
  localparam int SW      = NO_CH * SER_BW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             abort = 1'b0;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [DW-1:0]    in_data = '0;
  logic             mp_vld_in;
  logic [SW-1:0]    mp_data_in;
  logic             mp_vld_out = 1'b0;
  logic [DW-1:0]    mp_data_out = '0;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic [DW-1:0]    out_data;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] win_cnt;

  always #5 clk = ~clk;

  maxpool_seq_ctrl #(
    .NO_CH(NO_CH), .BW_IN(BW_IN), .SER_BW(SER_BW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .mp_vld_in(mp_vld_in), .mp_data_in(mp_data_in),
    .mp_vld_out(mp_vld_out), .mp_data_out(mp_data_out),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .busy(busy), .err(err), .win_cnt(win_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] res_q[$];
  logic [SW-1:0] slice_q[$];
  int exp_win = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signed per-channel maximum of two words
  function automatic logic [DW-1:0] pool(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic signed [BW_IN-1:0] x, y;
    r = '0;
    for (int c = 0; c < NO_CH; c++) begin
      x = a[c*BW_IN +: BW_IN];
      y = b[c*BW_IN +: BW_IN];
      r[c*BW_IN +: BW_IN] = (x > y) ? x : y;
    end
    return r;
  endfunction

  function automatic void push_slices(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [SW-1:0] s;
    logic [DW-1:0] src;
    for (int w = 0; w < 2; w++) begin
      src = (w == 0) ? a : b;
      for (int k = 0; k < CYC; k++) begin
        for (int c = 0; c < NO_CH; c++) s[c*SER_BW +: SER_BW] = src[c*BW_IN + k*SER_BW +: SER_BW];
        slice_q.push_back(s);
      end
    end
  endfunction

  // Maxpool stub: collects a contiguous burst, answers stub_lat cycles after it
  bit stub_en = 1'b1;
  int stub_lat = 1;
  int scnt = 0;
  bit pend = 1'b0;
  int cdown = 0;
  logic [DW-1:0] ca = '0, cb = '0, pres = '0;
  always @(posedge clk) begin
    #1;
    mp_vld_out = 1'b0;
    mp_data_out = '0;
    if (pend) begin
      if (cdown == 0) begin
        if (stub_en) begin
          mp_vld_out = 1'b1;
          mp_data_out = pres;
        end
        pend = 1'b0;
      end else cdown--;
    end
    if (!rst || !mp_vld_in) scnt = 0;
    else begin
      for (int c = 0; c < NO_CH; c++) begin
        if (scnt < CYC) ca[c*BW_IN + scnt*SER_BW +: SER_BW] = mp_data_in[c*SER_BW +: SER_BW];
        else            cb[c*BW_IN + (scnt-CYC)*SER_BW +: SER_BW] = mp_data_in[c*SER_BW +: SER_BW];
      end
      scnt++;
      if (scnt == 2*CYC) begin
        pres = pool(ca, cb);
        pend = 1'b1;
        cdown = stub_lat;
        scnt = 0;
      end
    end
  end

  // Scoreboard monitor
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (mp_vld_in) begin
        if (slice_q.size() == 0) check_eq("slice_unexpected", mp_vld_in, 0);
        else check_eq("slice", mp_data_in, slice_q.pop_front());
      end else begin
        check_eq("mp_data_idle", mp_data_in, 0);
      end
      if (out_vld && out_rdy) begin
        if (res_q.size() == 0) check_eq("result_unexpected", out_vld, 0);
        else begin
          exp_win = (exp_win + 1) % (1 << CNT_W);
          check_eq("result", out_data, res_q.pop_front());
          check_eq("win_cnt", win_cnt, exp_win);
        end
      end
    end
  end

  // Offer one word; returns at posedge+1 of the cycle after acceptance
  task automatic send_word(input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    in_vld = 1'b1;
    in_data = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    check_eq("in_accept", ok, 1);
  endtask

  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit want_res);
    send_word(a);
    send_word(b);
    if (want_res) res_q.push_back(pool(a, b));
    push_slices(a, b);
    check_eq("burst_start", mp_vld_in, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !busy && !out_vld && res_q.size() == 0 && slice_q.size() == 0;
    end
    check_eq("drain_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int c = 0; c < NO_CH; c++) w[c*BW_IN +: BW_IN] = BW_IN'($urandom);
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] a, b, a2, b2, r1;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_rdy", in_rdy, 0);
    check_eq("rst_mp_vld_in", mp_vld_in, 0);
    check_eq("rst_mp_data_in", mp_data_in, 0);
    check_eq("rst_out_vld", out_vld, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_win_cnt", win_cnt, 0);
    rst = 1'b1;
    out_rdy = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_rdy", in_rdy, 1);

    // 1: directed pair, ch0 A=0110 B=1011 -> signed max 0110
    a = '0; a[3:0] = 4'b0110;
    b = '0; b[3:0] = 4'b1011;
    send_pair(a, b, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = mp_vld_out;
    end
    check_eq("t1_mp_vld_out_seen", seen, 1);
    check_eq("t1_out_vld_before", out_vld, 0);
    @(negedge clk);
    check_eq("t1_out_vld_after", out_vld, 1);
    check_eq("t1_out_ch0", out_data[3:0], 4'b0110);
    check_eq("t1_win_cnt", win_cnt, 1);
    @(posedge clk); #1;
    wait_idle();

    // 2: result held while B is stalled by a full output buffer
    out_rdy = 1'b0;
    a = rnd_word(); b = rnd_word();
    r1 = pool(a, b);
    send_pair(a, b, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = out_vld;
    end
    check_eq("t2_first_result", seen, 1);
    @(posedge clk); #1;
    a2 = rnd_word(); b2 = rnd_word();
    send_word(a2);
    in_vld = 1'b1;
    in_data = b2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t2_b_stalled", in_rdy, 0);
      check_eq("t2_held_data", out_data, r1);
      check_eq("t2_held_vld", out_vld, 1);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    send_word(b2);
    res_q.push_back(pool(a2, b2));
    push_slices(a2, b2);
    check_eq("t2_burst_start", mp_vld_in, 1);
    wait_idle();

    // 3: stub never answers -> err after TIMEOUT wait cycles, no result
    stub_en = 1'b0;
    send_pair(rnd_word(), rnd_word(), 1'b0);
    repeat (2*CYC + TIMEOUT - 1) begin
      @(posedge clk); #1;
    end
    check_eq("t3_err_not_yet", err, 0);
    check_eq("t3_busy_wait", busy, 1);
    @(posedge clk); #1;
    check_eq("t3_err_set", err, 1);
    check_eq("t3_idle", busy, 0);
    check_eq("t3_no_result", out_vld, 0);
    check_eq("t3_win_cnt", win_cnt, exp_win);
    stub_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 4: abort on the second SHIFT cycle, then a clean window
    send_pair(rnd_word(), rnd_word(), 1'b1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("t4_vld_in_off", mp_vld_in, 0);
    check_eq("t4_busy_off", busy, 0);
    check_eq("t4_err_kept", err, 1);
    slice_q.delete();
    void'(res_q.pop_back());
    abort = 1'b1;
    in_vld = 1'b1;
    @(negedge clk);
    check_eq("t4_abort_blocks_rdy", in_rdy, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    in_vld = 1'b0;
    check_eq("t4_not_captured", busy, 0);
    send_pair(rnd_word(), rnd_word(), 1'b1);
    wait_idle();

    // 5: asynchronous reset mid-SHIFT, then a normal window
    send_pair(rnd_word(), rnd_word(), 1'b1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_eq("t5_mp_vld_in", mp_vld_in, 0);
    check_eq("t5_mp_data_in", mp_data_in, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_err", err, 0);
    check_eq("t5_out_vld", out_vld, 0);
    check_eq("t5_win_cnt", win_cnt, 0);
    check_eq("t5_in_rdy", in_rdy, 0);
    slice_q.delete();
    res_q.delete();
    exp_win = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_pair(rnd_word(), rnd_word(), 1'b1);
    wait_idle();
    check_eq("t5_win_after", win_cnt, 1);

    // 6: eight more back-to-back windows (nine since reset) -> win_cnt wraps to 1
    for (int w = 0; w < 8; w++) begin
      stub_lat = w % 3;
      send_pair(rnd_word(), rnd_word(), 1'b1);
    end
    wait_idle();
    check_eq("t6_wrap", win_cnt, 1);
    check_eq("t6_err_clear", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
